// File: rtl/muldiv.sv
`default_nettype none
// ============================================================================
// Module   : muldiv
// Purpose  : Iterative radix-2 multiply / restoring-divide unit that produces
//            the HI/LO pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_a_orig;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvsr;

    logic               w_op_signed;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_op_signed = (op == c_OP_MULT) || (op == c_OP_DIV);
    assign w_a_mag     = (w_op_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_b_mag     = (w_op_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Restoring step: bring in the next dividend bit, keep the trial difference
    // only when it did not borrow.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvsr};
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign w_prod_fix = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix  = r_neg_r ? (~r_rem + 1'b1) : r_rem;

    assign busy = (r_state == c_ST_RUN) || (r_state == c_ST_FIX);
    assign done = (r_state == c_ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_a_orig   <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (r_is_div) begin
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                    end
                    r_count <= r_count - 1'b1;
                    if (r_count == c_CNT_W'(1)) begin
                        r_state <= c_ST_FIX;
                    end
                end
                c_ST_FIX: begin
                    if (!r_is_div) begin
                        {hi, lo} <= w_prod_fix;
                    end else if (r_div_zero) begin
                        hi <= r_a_orig;
                        lo <= '1;
                    end else begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end
                    r_state <= c_ST_DONE;
                end
                default: begin
                    // IDLE and DONE accept a new request identically.
                    r_state <= c_ST_IDLE;
                    if (start) begin
                        case (op)
                            c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                                r_is_div   <= op[1];
                                r_neg_q    <= w_op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                                r_neg_r    <= (op == c_OP_DIV) && a[WIDTH-1];
                                r_div_zero <= (b == '0);
                                r_a_orig   <= a;
                                r_acc      <= '0;
                                r_mcand    <= {{WIDTH{1'b0}}, w_a_mag};
                                r_mplier   <= w_b_mag;
                                r_rem      <= '0;
                                r_quo      <= w_a_mag;
                                r_dvsr     <= w_b_mag;
                                r_count    <= c_CNT_W'(WIDTH);
                                r_state    <= c_ST_RUN;
                            end
                            c_OP_MTHI: hi <= a;
                            c_OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv
// Purpose  : Scoreboard bench for muldiv: directed ops push expected HI/LO,
//            a negedge monitor pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv;

    localparam int c_W = 32;

    localparam logic [2:0] c_MULT  = 3'b000;
    localparam logic [2:0] c_MULTU = 3'b001;
    localparam logic [2:0] c_DIV   = 3'b010;
    localparam logic [2:0] c_DIVU  = 3'b011;
    localparam logic [2:0] c_MTHI  = 3'b100;
    localparam logic [2:0] c_MTLO  = 3'b101;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2:0]     op = 3'b111;
    logic [c_W-1:0] a = '0;
    logic [c_W-1:0] b = '0;
    logic           busy;
    logic           done;
    logic [c_W-1:0] hi;
    logic [c_W-1:0] lo;

    typedef struct {
        string       name;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    exp_t r_pop;
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_cnt = 0;
    logic prev_done = 1'b0;

    muldiv #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_single", {63'd0, prev_done}, 64'd0);
                check("busy_len", 64'(busy_cnt), 64'd33);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
                end else begin
                    r_pop = sb.pop_front();
                    check(r_pop.name, {hi, lo}, r_pop.exp);
                end
            end
            if (busy) busy_cnt = busy_cnt + 1;
            else      busy_cnt = 0;
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0");
        end
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got done=0 expected done=1");
        end
    endtask

    // Drives one request from the current (negedge) point through the next edge.
    task automatic drive(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 3'b111;
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [63:0] exp, input bit push);
        wait_idle();
        if (push) sb.push_back('{name: name, exp: exp});
        drive(o, va, vb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100us");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) @(posedge clk);
        #2;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        issue("mult_neg1x2",  c_MULT,  32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        issue("multu_ffx2",   c_MULTU, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 1'b1);
        issue("div_m7_2",     c_DIV,   32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
        issue("divu_7_2",     c_DIVU,  32'd7,         32'd2, 64'h0000_0001_0000_0003, 1'b1);
        issue("divu_by0",     c_DIVU,  32'd5,         32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1);
        issue("div_by0",      c_DIV,   32'd5,         32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1);
        issue("div_ovf",      c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b1);

        // MTLO while busy must be dropped.
        issue("divu_100_7",   c_DIVU,  32'd100,       32'd7, 64'h0000_0002_0000_000E, 1'b1);
        repeat (5) @(negedge clk);
        drive(c_MTLO, 32'h0000_DEAD, 32'd0);
        check("mtlo_busy_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
        check("mtlo_busy_busy", {63'd0, busy}, 64'd1);

        // MTHI in the done cycle takes effect on the very next edge.
        wait_done();
        drive(c_MTHI, 32'h0000_1234, 32'd0);
        check("mthi_done", {hi, lo}, 64'h0000_1234_0000_000E);
        check("mthi_nobusy", {63'd0, busy}, 64'd0);

        // MULT launched in the done cycle of a DIV.
        issue("div_m20_3",    c_DIV,   32'hFFFF_FFEC, 32'd3, 64'hFFFF_FFFE_FFFF_FFFA, 1'b1);
        wait_done();
        sb.push_back('{name: "mult_b2b", exp: 64'hFFFF_FFFF_FFFF_FFEB});
        drive(c_MULT, 32'hFFFF_FFFD, 32'd7);
        check("b2b_busy", {63'd0, busy}, 64'd1);

        // Asynchronous reset 10 cycles into a DIV, no result expected.
        issue("div_abort",    c_DIV,   32'd1000,      32'd3, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_busy_done", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_idle", {62'd0, busy, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);

        issue("multu_3x5",    c_MULTU, 32'd3,         32'd5, 64'h0000_0000_0000_000F, 1'b1);

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit for the MIPS core's execute stage. It sits beside the main ALU and consumes the two register-file read operands (rs, rt). It produces the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO, and those values are read back through MFHI/MFLO. Each multiply or divide is a radix-2 shift-add or restoring-divide sequence of WIDTH steps, with a start/busy/done handshake that the controller uses to stall.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled on a rising edge only while busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 no-op
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  operation in progress; start ignored while high
- done  out  1  one-cycle pulse: HI/LO just updated by mult/div
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX, DONE. busy = (state==RUN or FIX). done = (state==DONE).
- IDLE/DONE with start=1:
  - MULT/MULTU/DIV/DIVU: latch operand magnitudes (two's-complement absolute value for signed ops, raw value for unsigned ops). Record the result sign flags, load step counter = WIDTH, and go to RUN.
  - MTHI: hi <= a. MTLO: lo <= a. Go to IDLE. busy stays 0 and no done pulse is produced.
  - op 110/111: no effect, go to IDLE.
- IDLE/DONE with start=0: go to IDLE (DONE always lasts exactly one cycle).
- RUN: one step per cycle and the counter decrements. When the counter reaches 0, go to FIX.
  - Multiply: shift-add into a 2×WIDTH accumulator.
  - Divide: restoring step with a WIDTH-bit remainder and quotient.
- FIX: apply the sign correction, write hi/lo, go to DONE.
  - Multiply: {hi,lo} = product, negated (2×WIDTH two's complement) if MULT and the operand signs differ.
  - Divide: lo = quotient, negated if DIV and the signs differ. hi = remainder, negated if DIV and a is negative (remainder takes the dividend's sign).
  - Divide by zero (b==0, DIV or DIVU): hi = a (original, unmodified), lo = all ones. This overrides the sign rules.
  - DIV with a = most-negative value and b = −1: lo = most-negative value, hi = 0. No exception is raised.
- hi/lo hold their value at all times except on a FIX edge or an MTHI/MTLO edge.
- start while busy=1: ignored entirely; operands and op are not captured.
- Reset (any time, including mid-RUN/FIX): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, and all internal accumulators are cleared. No partial result is ever written.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0.
- Call the edge that samples start (for a mult/div op) edge 0.
- busy: high after edge 0 through edge WIDTH+1, i.e. WIDTH+1 cycles (33 for WIDTH=32).
- RUN steps occur on edges 1..WIDTH. FIX writes hi/lo on edge WIDTH+1.
- done: high for exactly the cycle after edge WIDTH+1, and busy=0 in that cycle.
- Result latency: hi/lo are valid WIDTH+1 cycles after the start edge.
- Back-to-back: start asserted during the done cycle is accepted on the next edge, which gives a minimum spacing of WIDTH+2 cycles between mult/div starts.
- MTHI/MTLO: hi/lo change on the sampling edge itself (zero added latency).
- a, b and op need only be valid on the sampling edge.

## Test plan
- Reset: assert rst asynchronously mid-cycle. Required response: hi=0, lo=0, busy=0 and done=0 immediately, with no clock edge needed.
- Multiply, WIDTH=32:
  - MULT a=0xFFFFFFFF, b=0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE. busy is high for 33 cycles, then done pulses for one cycle.
  - MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- Divide:
  - DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
  - DIVU a=7, b=2 → lo=3, hi=1.
- Corner divides:
  - DIVU a=5, b=0 → hi=5, lo=0xFFFFFFFF.
  - DIV a=5, b=0 → hi=5, lo=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Handshake:
  - Pulse start with MTLO while busy → lo is unchanged and the in-flight result is unaffected.
  - MTHI a=0x1234 accepted in the done cycle → hi=0x1234 on the next edge, lo keeps the divide result.
  - A MULT started in the done cycle completes correctly.
- Reset mid-operation:
  - Assert rst 10 cycles into a DIV → busy drops, hi=lo=0, and no done pulse occurs.
  - After reset is released, MULTU a=3, b=5 → lo=15, hi=0 after 33 cycles.
